// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback stages and the multi-port register file.
// The master drives reads, writes and reservations; the slave is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     init_done;
    logic                     wr_conflict;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, init_done, wr_conflict
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, init_done, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: bypassed reads, two write ports,
// busy scoreboard and a sequential clear engine that runs after every reset.
//   state   | meaning
//   ST_INIT | clearing mem[ptr] each cycle, all traffic ignored, reads return 0
//   ST_RUN  | normal operation, init_done high until next reset
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                conflict_q, conflict_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                wa_ok, wb_ok, rsv_ok;
    logic [ADDR_W-1:0]   ra;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]   rd_busy;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign run    = (state_q == ST_RUN);
    assign wa_ok  = run && bus.wa_en  && !is_zero(bus.wa_addr);
    assign wb_ok  = run && bus.wb_en  && !is_zero(bus.wb_addr);
    assign rsv_ok = run && bus.rsv_en && !is_zero(bus.rsv_addr);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        conflict_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Clear before set so a same-cycle reservation wins.
                if (wa_ok)  busy_d[bus.wa_addr]  = 1'b0;
                if (wb_ok)  busy_d[bus.wb_addr]  = 1'b0;
                if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
                conflict_d = wa_ok && wb_ok && (bus.wa_addr == bus.wb_addr);
            end
        endcase
    end

    // No reset on the array: the clear engine zeroes it after each reset.
    always_ff @(posedge sys_clk) begin
        if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (wb_ok && !(wa_ok && (bus.wb_addr == bus.wa_addr))) mem_q[bus.wb_addr] <= bus.wb_data;
            if (wa_ok) mem_q[bus.wa_addr] <= bus.wa_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (run && !is_zero(ra)) begin
                if (bus.wa_en && (ra == bus.wa_addr))      rd_data[k*DATA_W +: DATA_W] = bus.wa_data;
                else if (bus.wb_en && (ra == bus.wb_addr)) rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
                else                                       rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
                rd_busy[k] = busy_q[ra] && !(wa_ok && (ra == bus.wa_addr))
                                        && !(wb_ok && (ra == bus.wb_addr));
            end
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.rd_busy     = rd_busy;
    assign bus.init_done   = run;
    assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps plus randomized traffic
// against a behavioural register-file model; second instance with 8 regs, 4 read ports.
module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int AW2 = 3;
    localparam int NR2 = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW),  .NUM_RD(NR))  u_if ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW2), .NUM_RD(NR2)) s_if ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(u_if)
    );
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW2), .NUM_RD(NR2), .ZERO_REG(1)) s_dut (
        .sys_clk(clk), .sys_rst_n(rst2_n), .bus(s_if)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem_m [32];
    bit            busy_m [32];
    bit            conf_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
        conf_m = 1'b0;
    endtask

    task automatic idle();
        u_if.wa_en  = 1'b0;
        u_if.wb_en  = 1'b0;
        u_if.rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        u_if.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return u_if.rd_data[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] srd(input int p);
        return s_if.rd_data[p*DW +: DW];
    endfunction

    function automatic bit a_ok();
        return u_if.wa_en && (u_if.wa_addr != 0);
    endfunction

    function automatic bit b_ok();
        return u_if.wb_en && (u_if.wb_addr != 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (u_if.wa_en && a == int'(u_if.wa_addr)) return u_if.wa_data;
        if (u_if.wb_en && a == int'(u_if.wb_addr)) return u_if.wb_data;
        return mem_m[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (a_ok() && a == int'(u_if.wa_addr)) return 1'b0;
        if (b_ok() && a == int'(u_if.wb_addr)) return 1'b0;
        return busy_m[a];
    endfunction

    task automatic check_all();
        int a;
        for (int k = 0; k < NR; k++) begin
            a = int'(u_if.rd_addr[k*AW +: AW]);
            chk($sformatf("rd_data%0d_x%0d", k, a), rd(k), exp_rd(a));
            chk($sformatf("rd_busy%0d_x%0d", k, a), u_if.rd_busy[k], exp_busy(a));
        end
        chk("wr_conflict", u_if.wr_conflict, conf_m);
        chk("init_done_run", u_if.init_done, 1'b1);
    endtask

    task automatic model_update();
        bit ao, bo;
        ao = a_ok();
        bo = b_ok();
        if (bo && !(ao && u_if.wb_addr == u_if.wa_addr)) mem_m[u_if.wb_addr] = u_if.wb_data;
        if (ao) mem_m[u_if.wa_addr] = u_if.wa_data;
        conf_m = ao && bo && (u_if.wa_addr == u_if.wb_addr);
        if (ao) busy_m[u_if.wa_addr] = 1'b0;
        if (bo) busy_m[u_if.wb_addr] = 1'b0;
        if (u_if.rsv_en && u_if.rsv_addr != 0) busy_m[u_if.rsv_addr] = 1'b1;
    endtask

    // Inputs are set just after a falling edge; check, advance model, move to next falling edge.
    task automatic run_cycle();
        #1;
        check_all();
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_init_main(input string tag);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("%s_low_e%0d", tag, i), u_if.init_done, 1'b0);
            chk($sformatf("%s_rd0_e%0d", tag, i), rd(0), '0);
            chk($sformatf("%s_busy_e%0d", tag, i), u_if.rd_busy, '0);
            @(negedge clk);
        end
        #1;
        chk($sformatf("%s_high", tag), u_if.init_done, 1'b1);
    endtask

    task automatic wait_init_small(input string tag);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("%s_low_e%0d", tag, i), s_if.init_done, 1'b0);
            @(negedge clk);
        end
        #1;
        chk($sformatf("%s_high", tag), s_if.init_done, 1'b1);
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        u_if.rd_addr = '0; u_if.wa_addr = '0; u_if.wa_data = '0; u_if.wb_addr = '0;
        u_if.wb_data = '0; u_if.rsv_addr = '0; idle();
        s_if.rd_addr = '0; s_if.wa_en = 1'b0; s_if.wa_addr = '0; s_if.wa_data = '0;
        s_if.wb_en = 1'b0; s_if.wb_addr = '0; s_if.wb_data = '0; s_if.rsv_en = 1'b0; s_if.rsv_addr = '0;
        model_reset();

        // Reset state, then clear sequence with traffic that must be ignored.
        @(negedge clk);
        #1;
        chk("rst_init_done", u_if.init_done, 1'b0);
        chk("rst_wr_conflict", u_if.wr_conflict, 1'b0);
        chk("rst_rd0", rd(0), '0);
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd5; u_if.wa_data = 32'hDEAD;
        u_if.rsv_en = 1'b1; u_if.rsv_addr = 5'd5;
        set_rd(0, 5); set_rd(1, 5);
        rst_n = 1'b1;
        wait_init_main("init");
        idle();
        #1;
        chk("init_write_dropped", rd(0), '0);
        chk("init_rsv_dropped", u_if.rd_busy[0], 1'b0);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            set_rd(0, a); set_rd(1, 31 - a);
            run_cycle();
        end

        // Bypass then memory read.
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd3; u_if.wa_data = 32'h1234_5678; set_rd(0, 3);
        #1 chk("bypass_x3", rd(0), 32'h1234_5678);
        run_cycle();
        idle();
        #1 chk("mem_x3", rd(0), 32'h1234_5678);
        run_cycle();

        // Write conflict: A wins, pulse one cycle.
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd7; u_if.wa_data = 32'hAAAA_AAAA;
        u_if.wb_en = 1'b1; u_if.wb_addr = 5'd7; u_if.wb_data = 32'h5555_5555;
        set_rd(0, 7); set_rd(1, 7);
        #1 chk("conflict_bypass", rd(0), 32'hAAAA_AAAA);
        chk("conflict_pre", u_if.wr_conflict, 1'b0);
        run_cycle();
        idle();
        #1 chk("conflict_mem", rd(1), 32'hAAAA_AAAA);
        chk("conflict_pulse", u_if.wr_conflict, 1'b1);
        run_cycle();
        #1 chk("conflict_end", u_if.wr_conflict, 1'b0);
        run_cycle();

        // Scoreboard.
        u_if.rsv_en = 1'b1; u_if.rsv_addr = 5'd9; set_rd(1, 9);
        #1 chk("rsv_same_cycle", u_if.rd_busy[1], 1'b0);
        run_cycle();
        idle();
        #1 chk("rsv_busy", u_if.rd_busy[1], 1'b1);
        run_cycle();
        u_if.wb_en = 1'b1; u_if.wb_addr = 5'd9; u_if.wb_data = 32'h42;
        #1 chk("wb_clears_busy", u_if.rd_busy[1], 1'b0);
        chk("wb_bypass_x9", rd(1), 32'h42);
        run_cycle();
        idle();
        #1 chk("busy_cleared", u_if.rd_busy[1], 1'b0);
        chk("mem_x9", rd(1), 32'h42);
        run_cycle();
        u_if.rsv_en = 1'b1; u_if.rsv_addr = 5'd9;
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd9; u_if.wa_data = 32'h77;
        run_cycle();
        idle();
        #1 chk("rsv_beats_clear", u_if.rd_busy[1], 1'b1);
        chk("rsv_write_x9", rd(1), 32'h77);
        run_cycle();

        // Register 0 hardwired.
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd0; u_if.wa_data = 32'hFFFF_FFFF;
        u_if.rsv_en = 1'b1; u_if.rsv_addr = 5'd0; set_rd(0, 0); set_rd(1, 0);
        #1 chk("x0_bypass_zero", rd(0), '0);
        chk("x0_busy_zero", u_if.rd_busy[0], 1'b0);
        run_cycle();
        idle();
        #1 chk("x0_mem_zero", rd(1), '0);
        chk("x0_busy_after", u_if.rd_busy[1], 1'b0);
        run_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            u_if.wa_en    = ($urandom_range(0, 1) == 1);
            u_if.wa_addr  = AW'(rnd_addr());
            u_if.wa_data  = $urandom;
            u_if.wb_en    = ($urandom_range(0, 2) == 0);
            u_if.wb_addr  = AW'(rnd_addr());
            u_if.wb_data  = $urandom;
            u_if.rsv_en   = ($urandom_range(0, 2) == 0);
            u_if.rsv_addr = AW'(rnd_addr());
            set_rd(0, rnd_addr());
            set_rd(1, rnd_addr());
            run_cycle();
        end

        // Reset mid-RUN.
        idle();
        u_if.wa_en = 1'b1; u_if.wa_addr = 5'd4; u_if.wa_data = 32'h99;
        run_cycle();
        idle(); set_rd(0, 4);
        #1 chk("x4_before_rst", rd(0), 32'h99);
        rst_n = 1'b0;
        #1 chk("midrun_rst_done", u_if.init_done, 1'b0);
        chk("midrun_rst_conflict", u_if.wr_conflict, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_init_main("reinit");
        chk("x4_after_rst", rd(0), '0);
        @(negedge clk);
        run_cycle();

        // Small configuration: 8 registers, 4 read ports, reset during INIT.
        rst2_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1 chk("s_partial_init", s_if.init_done, 1'b0);
        rst2_n = 1'b0;
        #1 chk("s_midinit_rst", s_if.init_done, 1'b0);
        @(negedge clk);
        rst2_n = 1'b1;
        wait_init_small("s_init");
        @(negedge clk);
        s_if.wa_en = 1'b1; s_if.wa_addr = 3'd4; s_if.wa_data = 32'h99;
        s_if.wb_en = 1'b1; s_if.wb_addr = 3'd5; s_if.wb_data = 32'h55;
        s_if.rd_addr = {3'd6, 3'd0, 3'd5, 3'd4};
        #1 chk("s_byp_a", srd(0), 32'h99);
        chk("s_byp_b", srd(1), 32'h55);
        chk("s_x0", srd(2), '0);
        chk("s_x6_cleared", srd(3), '0);
        chk("s_no_conflict", s_if.wr_conflict, 1'b0);
        @(negedge clk);
        s_if.wa_en = 1'b0; s_if.wb_en = 1'b0;
        s_if.rd_addr = {3'd5, 3'd4, 3'd4, 3'd5};
        #1 chk("s_mem0", srd(0), 32'h55);
        chk("s_mem1", srd(1), 32'h99);
        chk("s_mem2", srd(2), 32'h99);
        chk("s_mem3", srd(3), 32'h55);
        chk("s_busy", s_if.rd_busy, 4'b0000);
        rst2_n = 1'b0;
        #1 chk("s_rst_done", s_if.init_done, 1'b0);
        @(negedge clk);
        rst2_n = 1'b1;
        wait_init_small("s_reinit");
        for (int k = 0; k < NR2; k++) chk($sformatf("s_after_rst%0d", k), srd(k), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
